// File: rtl/clint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clint_pkg
// Description : Shared register offsets, widths and address decode helper
//               for the core-local interruptor (CLINT).
//               Optional feature macro: CLINT_MSIP_EN (adds msip at 0x0000).
// Revision    : 1.0 - initial release
// ============================================================================
package clint_pkg;

    localparam int unsigned CLINT_TIME_W      = 64;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_MSIP    = 3'd1,
        SEL_CMP_LO  = 3'd2,
        SEL_CMP_HI  = 3'd3,
        SEL_TIME_LO = 3'd4,
        SEL_TIME_HI = 3'd5
    } reg_sel_e;

    // Word-granular decode; byte-lane bits are stripped by the caller.
    function automatic reg_sel_e decode_offset(input logic [13:0] word);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word == CLINT_MTIMECMP_LO[15:2]) sel = SEL_CMP_LO;
        if (word == CLINT_MTIMECMP_HI[15:2]) sel = SEL_CMP_HI;
        if (word == CLINT_MTIME_LO[15:2])    sel = SEL_TIME_LO;
        if (word == CLINT_MTIME_HI[15:2])    sel = SEL_TIME_HI;
`ifdef CLINT_MSIP_EN
        if (word == CLINT_MSIP[15:2])        sel = SEL_MSIP;
`endif
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clint_if.sv
`default_nettype none
// ============================================================================
// Module      : clint_if
// Description : Single-cycle register access bus between a host and the
//               CLINT. One request per cycle, ack one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
interface clint_if;
    logic        req_i;
    logic        we_i;
    logic [15:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ack_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o
    );
endinterface
`default_nettype wire

// File: rtl/clint_timer.sv
`default_nettype none
// ============================================================================
// Module      : clint_timer
// Description : Prescaler plus 64-bit mtime counter. Software writes to
//               either half win over the same-cycle increment and restart
//               the prescaler; halt freezes both prescaler and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  wire                     clk,
    input  wire                     rst_n,
    input  wire                     halt,
    input  wire                     wr_lo,
    input  wire                     wr_hi,
    input  wire [31:0]              wdata,
    output logic [CLINT_TIME_W-1:0] mtime
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [15:0] presc;
    logic [31:0] mtime_lo;
    logic [31:0] mtime_hi;
    logic        tick;
    logic        lo_carry;

    // A tick fires on the last prescaler count of each period.
    assign tick     = !halt && (presc == PRESC_MAX);
    // Carry only when the low half really increments past all-ones.
    assign lo_carry = tick && !wr_lo && (mtime_lo == 32'hFFFF_FFFF);

    // Prescaler: restart on any mtime write, hold while halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (wr_lo || wr_hi) begin
            presc <= '0;
        end else if (!halt) begin
            presc <= tick ? 16'd0 : presc + 16'd1;
        end
    end

    // Low half: software load has priority over the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_lo <= '0;
        end else if (wr_lo) begin
            mtime_lo <= wdata;
        end else if (tick) begin
            mtime_lo <= mtime_lo + 32'd1;
        end
    end

    // High half: software load suppresses the carry from the low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_hi <= '0;
        end else if (wr_hi) begin
            mtime_hi <= wdata;
        end else if (lo_carry) begin
            mtime_hi <= mtime_hi + 32'd1;
        end
    end

    assign mtime = {mtime_hi, mtime_lo};

endmodule
`default_nettype wire

// File: rtl/clint.sv
`default_nettype none
// ============================================================================
// Module      : clint
// Description : Core-local interruptor: mtime / mtimecmp register block with
//               a registered machine timer interrupt. Optional msip register
//               and soft_irq_o output when CLINT_MSIP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module clint
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  wire       clk,
    input  wire       rst_n,
    clint_if.slave    bus,
    input  wire       halt_i,
    output logic      timer_irq_o
`ifdef CLINT_MSIP_EN
    ,
    output logic      soft_irq_o
`endif
);

    reg_sel_e                sel;
    logic                    wr_en;
    logic [CLINT_TIME_W-1:0] mtime;
    logic [CLINT_TIME_W-1:0] mtimecmp;
    logic [31:0]             read_val;
    logic [31:0]             rdata;
    logic                    ack;
    logic                    unused_addr;

    // Byte-lane bits carry no meaning for full-word accesses.
    assign unused_addr = ^bus.addr_i[1:0];
    assign sel         = decode_offset(bus.addr_i[15:2]);
    assign wr_en       = bus.req_i && bus.we_i;

    clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .halt  (halt_i),
        .wr_lo (wr_en && (sel == SEL_TIME_LO)),
        .wr_hi (wr_en && (sel == SEL_TIME_HI)),
        .wdata (bus.wdata_i),
        .mtime (mtime)
    );

    // Compare register resets to all-ones so no interrupt fires by default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= '1;
        end else begin
            if (wr_en && (sel == SEL_CMP_LO)) mtimecmp[31:0]  <= bus.wdata_i;
            if (wr_en && (sel == SEL_CMP_HI)) mtimecmp[63:32] <= bus.wdata_i;
        end
    end

`ifdef CLINT_MSIP_EN
    logic msip;

    // Software interrupt pending bit; only bit 0 is storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip <= 1'b0;
        end else if (wr_en && (sel == SEL_MSIP)) begin
            msip <= bus.wdata_i[0];
        end
    end

    assign soft_irq_o = msip;
`endif

    // Read mux over the current register values; unmapped offsets read 0.
    always_comb begin
        read_val = '0;
        case (sel)
            SEL_CMP_LO:  read_val = mtimecmp[31:0];
            SEL_CMP_HI:  read_val = mtimecmp[63:32];
            SEL_TIME_LO: read_val = mtime[31:0];
            SEL_TIME_HI: read_val = mtime[63:32];
`ifdef CLINT_MSIP_EN
            SEL_MSIP:    read_val = {31'b0, msip};
`endif
            default:     read_val = '0;
        endcase
    end

    // Response stage: ack every request one cycle later; data is zero
    // whenever the ack is low or the access was a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= bus.req_i;
            rdata <= (bus.req_i && !bus.we_i) ? read_val : 32'h0;
        end
    end

    assign bus.ack_o   = ack;
    assign bus.rdata_o = rdata;

    // Level interrupt from the previous cycle's mtime / mtimecmp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_irq_o <= 1'b0;
        end else begin
            timer_irq_o <= (mtime >= mtimecmp);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clint.sv
`default_nettype none
// ============================================================================
// Module      : tb_clint
// Description : Self-checking bench for clint. Three instances (TICK_DIV 1,
//               3 and 4) share one stimulus bus; each check targets one of
//               them. Build with CLINT_MSIP_EN defined to cover msip.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clint;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        irq1, irq3, irq4;
`ifdef CLINT_MSIP_EN
    logic        soft1, soft3, soft4;
    localparam logic [31:0] MSIP_EXP = 32'h1;
`else
    localparam logic [31:0] MSIP_EXP = 32'h0;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clint_if b1 ();
    clint_if b3 ();
    clint_if b4 ();

    assign b1.req_i = req;  assign b1.we_i = we;  assign b1.addr_i = addr;  assign b1.wdata_i = wdata;
    assign b3.req_i = req;  assign b3.we_i = we;  assign b3.addr_i = addr;  assign b3.wdata_i = wdata;
    assign b4.req_i = req;  assign b4.we_i = we;  assign b4.addr_i = addr;  assign b4.wdata_i = wdata;

    clint #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .halt_i(halt), .timer_irq_o(irq1)
`ifdef CLINT_MSIP_EN
        , .soft_irq_o(soft1)
`endif
    );

    clint #(.TICK_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3), .halt_i(halt), .timer_irq_o(irq3)
`ifdef CLINT_MSIP_EN
        , .soft_irq_o(soft3)
`endif
    );

    clint #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4), .halt_i(halt), .timer_irq_o(irq4)
`ifdef CLINT_MSIP_EN
        , .soft_irq_o(soft4)
`endif
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; presents one access, returns at the next negedge
    // with the response of the selected instance.
    task automatic bus_op(input int inst, input logic w, input logic [15:0] a,
                          input logic [31:0] d, output logic ack, output logic [31:0] rd);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        case (inst)
            1:       begin ack = b1.ack_o; rd = b1.rdata_o; end
            3:       begin ack = b3.ack_o; rd = b3.rdata_o; end
            default: begin ack = b4.ack_o; rd = b4.rdata_o; end
        endcase
    endtask

    task automatic rd_chk(input int inst, input logic [15:0] a, input logic [31:0] exp, input string name);
        logic        ack;
        logic [31:0] rd;
        bus_op(inst, 1'b0, a, 32'h0, ack, rd);
        check(name, {31'b0, ack, rd}, {31'b0, 1'b1, exp});
    endtask

    task automatic wr_chk(input int inst, input logic [15:0] a, input logic [31:0] d, input string name);
        logic        ack;
        logic [31:0] rd;
        bus_op(inst, 1'b1, a, d, ack, rd);
        check(name, {31'b0, ack, rd}, {31'b0, 1'b1, 32'h0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a0, a1, a2, a3, flag, ack;
        logic [31:0] r0, r1, r2, r3, rd;

        tbl[0]  = '{1'b0, 16'hBFF8, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 16'hBFFC, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 16'h4000, 32'h0,        32'hFFFF_FFFF};
        tbl[3]  = '{1'b0, 16'h4004, 32'h0,        32'hFFFF_FFFF};
        tbl[4]  = '{1'b0, 16'h0000, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, 16'h4000, 32'h1234_5678, 32'h0};
        tbl[6]  = '{1'b0, 16'h4000, 32'h0,        32'h1234_5678};
        tbl[7]  = '{1'b1, 16'h4004, 32'h9ABC_DEF0, 32'h0};
        tbl[8]  = '{1'b0, 16'h4004, 32'h0,        32'h9ABC_DEF0};
        tbl[9]  = '{1'b0, 16'h4003, 32'h0,        32'h1234_5678};
        tbl[10] = '{1'b1, 16'hBFF8, 32'hDEAD_BEEF, 32'h0};
        tbl[11] = '{1'b0, 16'hBFF8, 32'h0,        32'hDEAD_BEEF};
        tbl[12] = '{1'b0, 16'hBFFC, 32'h0,        32'h0};
        tbl[13] = '{1'b1, 16'hBFFC, 32'h0000_0001, 32'h0};
        tbl[14] = '{1'b0, 16'hBFFC, 32'h0,        32'h0000_0001};
        tbl[15] = '{1'b0, 16'hBFF8, 32'h0,        32'hDEAD_BEEF};
        tbl[16] = '{1'b1, 16'h1234, 32'hFFFF_FFFF, 32'h0};
        tbl[17] = '{1'b0, 16'h1234, 32'h0,        32'h0};
        tbl[18] = '{1'b0, 16'h0008, 32'h0,        32'h0};
        tbl[19] = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 32'h0};
        tbl[20] = '{1'b0, 16'h0000, 32'h0,        MSIP_EXP};
        tbl[21] = '{1'b0, 16'h4000, 32'h0,        32'h1234_5678};

        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; halt = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state of outputs
        check("rst_ack",   {63'b0, b1.ack_o}, 64'h0);
        check("rst_rdata", {32'b0, b1.rdata_o}, 64'h0);
        check("rst_irq",   {61'b0, irq1, irq3, irq4}, 64'h0);
`ifdef CLINT_MSIP_EN
        check("rst_soft",  {61'b0, soft1, soft3, soft4}, 64'h0);
`endif

        // Free run after reset, TICK_DIV = 1: mtime equals edges since release
        rst_n = 1'b1;
        flag  = 1'b0;
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            if (irq1) flag = 1'b1;
        end
        rd_chk(1, 16'hBFF8, 32'h0000_000A, "run10_lo");
        rd_chk(1, 16'hBFFC, 32'h0, "run10_hi");
        check("run_irq_quiet", {63'b0, flag | irq1}, 64'h0);

        // Reset asserted while an ack is pending
        halt = 1'b1;
        req = 1'b1; we = 1'b0; addr = 16'hBFF8;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        req = 1'b0;
        check("midrst_ack", {31'b0, b1.ack_o, b1.rdata_o}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (b1.ack_o) flag = 1'b1;
        end
        check("postrst_no_ack", {63'b0, flag}, 64'h0);

        // Register map table (halted so mtime is stable)
        for (int i = 0; i < NVEC; i++) begin
            bus_op(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, ack, rd);
            check($sformatf("vec%0d_%h", i, tbl[i].addr), {31'b0, ack, rd}, {31'b0, 1'b1, tbl[i].exp});
        end
        check("tbl_irq", {63'b0, irq1}, 64'h0);
`ifdef CLINT_MSIP_EN
        check("tbl_soft", {63'b0, soft1}, 64'h1);
`endif

        // Compare at 0x20 with TICK_DIV = 1
        wr_chk(1, 16'h4000, 32'h20, "cmp_lo_w");
        wr_chk(1, 16'hBFF8, 32'h0,  "time_lo_w");
        wr_chk(1, 16'hBFFC, 32'h0,  "time_hi_w");
        wr_chk(1, 16'h4004, 32'h0,  "cmp_hi_w");
        halt = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("irq_c%0d", c), {63'b0, irq1}, {63'b0, (c >= 33)});
        end
        wr_chk(1, 16'h4004, 32'h1, "cmp_hi_raise");
        check("irq_hold_wr", {63'b0, irq1}, 64'h1);
        @(posedge clk); @(negedge clk);
        check("irq_cleared", {63'b0, irq1}, 64'h0);

        // Wrap with TICK_DIV = 4
        halt = 1'b1;
        wr_chk(4, 16'hBFF8, 32'hFFFF_FFFF, "wrap_lo_w");
        wr_chk(4, 16'hBFFC, 32'hFFFF_FFFF, "wrap_hi_w");
        halt = 1'b0;
        for (int k = 1; k <= 5; k++)
            rd_chk(4, 16'hBFFC, (k <= 4) ? 32'hFFFF_FFFF : 32'h0, $sformatf("wrap_hi_r%0d", k));
        rd_chk(4, 16'hBFF8, 32'h0, "wrap_lo_r");

        // High-half write in the carry cycle wins over the carry
        halt = 1'b1;
        wr_chk(4, 16'hBFF8, 32'hFFFF_FFFF, "carry_lo_w");
        wr_chk(4, 16'hBFFC, 32'hFFFF_FFFF, "carry_hi_w");
        halt = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        wr_chk(4, 16'hBFFC, 32'h55, "carry_cycle_w");
        halt = 1'b1;
        rd_chk(4, 16'hBFF8, 32'h0,  "carry_lo_r");
        rd_chk(4, 16'hBFFC, 32'h55, "carry_hi_r");

        // Halt window with TICK_DIV = 3; prescaler held at count 1
        wr_chk(3, 16'hBFF8, 32'h100, "halt_lo_w");
        wr_chk(3, 16'hBFFC, 32'h0,   "halt_hi_w");
        halt = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        halt = 1'b1;
        rd_chk(3, 16'hBFF8, 32'h101, "halt_start");
        repeat (48) begin @(posedge clk); @(negedge clk); end
        rd_chk(3, 16'hBFF8, 32'h101, "halt_end");
        halt = 1'b0;
        rd_chk(3, 16'hBFF8, 32'h101, "resume1");
        rd_chk(3, 16'hBFF8, 32'h101, "resume2");
        rd_chk(3, 16'hBFF8, 32'h102, "resume3");

        // Back-to-back read / unmapped write / offset 0 read
        halt = 1'b1;
        wr_chk(1, 16'hBFF8, 32'hCAFE_0000, "b2b_setup");
        req = 1'b1; we = 1'b0; addr = 16'hBFF8;
        @(posedge clk); @(negedge clk);
        a0 = b1.ack_o; r0 = b1.rdata_o;
        we = 1'b1; addr = 16'h1234; wdata = 32'h5;
        @(posedge clk); @(negedge clk);
        a1 = b1.ack_o; r1 = b1.rdata_o;
        we = 1'b0; addr = 16'h0000;
        @(posedge clk); @(negedge clk);
        a2 = b1.ack_o; r2 = b1.rdata_o;
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        a3 = b1.ack_o; r3 = b1.rdata_o;
        check("b2b_rd_time", {31'b0, a0, r0}, {31'b0, 1'b1, 32'hCAFE_0000});
        check("b2b_wr_unmap", {31'b0, a1, r1}, {31'b0, 1'b1, 32'h0});
        check("b2b_rd_0000", {31'b0, a2, r2}, {31'b0, 1'b1, MSIP_EXP});
        check("b2b_idle", {31'b0, a3, r3}, 64'h0);

`ifdef CLINT_MSIP_EN
        check("soft_before", {63'b0, soft1}, 64'h1);
        wr_chk(1, 16'h0000, 32'h0, "msip_clr");
        check("soft_clr", {63'b0, soft1}, 64'h0);
        wr_chk(1, 16'h0000, 32'h2, "msip_bit1");
        check("soft_bit1", {63'b0, soft1}, 64'h0);
        rd_chk(1, 16'h0000, 32'h0, "msip_rd0");
        wr_chk(1, 16'h0000, 32'h3, "msip_set");
        check("soft_set", {63'b0, soft1}, 64'h1);
        rd_chk(1, 16'h0000, 32'h1, "msip_rd1");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1: clk cycles per mtime increment, legal range 1..65535.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_i, input, 1: register access request, one access per cycle.
REQ-005 SHALL have port we_i, input, 1: 1 = write, 0 = read; qualified by req_i.
REQ-006 SHALL have port addr_i, input, 16: byte offset, word aligned; bits [1:0] ignored.
REQ-007 SHALL have port wdata_i, input, 32: write data, full-word writes only.
REQ-008 SHALL have port rdata_o, output, 32: read data, valid while ack_o = 1.
REQ-009 SHALL have port ack_o, output, 1: access completion.
REQ-010 SHALL have port halt_i, input, 1: freezes the prescaler and mtime (debug halt).
REQ-011 SHALL have port timer_irq_o, output, 1: machine timer interrupt, feeds the exception unit's timer_irq_i.

Function
REQ-012 Register map SHALL be: 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32], 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32].
REQ-013 Every access with req_i = 1 in cycle N SHALL produce ack_o = 1 in cycle N+1 for exactly one cycle; back-to-back requests SHALL be acked every cycle.
REQ-014 Read data SHALL be the register value sampled in cycle N and presented in cycle N+1; ack_o = 0 SHALL force rdata_o = 0.
REQ-015 Unmapped offsets SHALL read 0, ignore writes, and still ack.
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 while halt_i = 0; mtime SHALL increment by 1 in the cycle the count equals TICK_DIV-1; TICK_DIV = 1 SHALL increment every cycle.
REQ-017 mtime SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-018 A write to either mtime half SHALL load that half and keep the other half, take priority over a same-cycle increment, and clear the prescaler count.
REQ-019 A carry from mtime[31:0] into mtime[63:32] SHALL occur only when no write to mtime[63:32] occurs in the same cycle.
REQ-020 halt_i = 1 SHALL hold the prescaler and mtime; register writes SHALL still take effect.
REQ-021 timer_irq_o SHALL be registered and equal to (mtime >= mtimecmp, unsigned 64-bit) evaluated on the previous cycle's register values, giving 1-cycle latency.
REQ-022 timer_irq_o SHALL stay level-high until software raises mtimecmp above mtime or mtime wraps below mtimecmp.

Reset
REQ-023 On rst_n = 0, mtime, the prescaler, ack_o, rdata_o and timer_irq_o SHALL be 0, and mtimecmp SHALL be 0xFFFF_FFFF_FFFF_FFFF.
REQ-024 Reset mid-access SHALL drop the pending ack; no ack SHALL be issued after reset releases.

Configuration
REQ-025 With CLINT_MSIP_EN defined, the block SHALL add output soft_irq_o (1 bit, registered) and register msip at 0x0000, where bit 0 is R/W, bits [31:1] read 0, and soft_irq_o = msip[0] one cycle after the write.
REQ-026 With CLINT_MSIP_EN undefined, no soft_irq_o port SHALL exist and offset 0x0000 SHALL behave as unmapped.
REQ-027 msip SHALL reset to 0.

Structure
REQ-028 Register offsets (CLINT_MSIP, CLINT_MTIMECMP_LO/HI, CLINT_MTIME_LO/HI) and the 64-bit width constant SHALL live in the shared defines file.
REQ-029 The prescaler and the mtime counter SHALL form one sub-module, clint_timer; the bus decode and compare logic SHALL stay in clint.

Verification
REQ-030 Reset release with no writes, TICK_DIV = 1: mtime reads 0x0000_000A ten cycles after release; timer_irq_o stays 0.
REQ-031 Write mtimecmp = 0x0000_0000_0000_0020, TICK_DIV = 1: timer_irq_o rises exactly one cycle after mtime reaches 0x20 and holds; writing mtimecmp_hi = 1 clears it one cycle later.
REQ-032 Write mtime = 0xFFFF_FFFF / 0xFFFF_FFFF, TICK_DIV = 4: mtime wraps to 0 four cycles later; writing mtime_hi in the carry cycle keeps the written high value.
REQ-033 halt_i = 1 for 50 cycles, TICK_DIV = 3: mtime is unchanged across the window; the prescaler resumes from its held count.
REQ-034 Back-to-back read of 0xBFF8, write of 0x1234, then read of 0x0000: three consecutive acks; the unmapped read returns 0, or msip with CLINT_MSIP_EN defined, and soft_irq_o is checked in that build.
